cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Initiator-side converter between the cache's 256-bit line interface and the burst physical-memory interface served by the parameterized memory model (4 bursts × 64 bits per 256-bit line). It accepts one line read or line write from the cache and runs the matching 4-beat burst transaction on the memory port. It returns `resp_o` when the line transfer is complete. It sits between the cache/arbiter and `mem_itf` at the top of the CPU.

## Interface
- `BURSTS`, 4, beats per line
- `BURST_W`, 64, bits per beat; line width = `BURSTS*BURST_W` (256)
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset; synchronous, active-high
- `address_i`  in  32  cache line address
- `read_i`  in  1  line read request; held until `resp_o`
- `write_i`  in  1  line write request; held until `resp_o`
- `line_i`  in  256  write line; beat k = `line_i[64k +: 64]`
- `line_o`  out  256  read line; beat k is stored at `[64k +: 64]`
- `resp_o`  out  1  one-cycle completion pulse
- `address_o`  out  32  memory address, line-aligned
- `read_o`  out  1  memory burst read
- `write_o`  out  1  memory burst write
- `burst_o`  out  64  current write beat
- `burst_i`  in  64  read beat from memory
- `resp_i`  in  1  memory beat strobe (one beat per high cycle)
- `proto_err_o`  out  1  sticky: `resp_i` seen while no transaction is active

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Beat counter `k` is 2 bits wide (log2 `BURSTS`).
- IDLE:
  - `read_i` → latch `{address_i[31:5],5'b0}` into the address register, set k=0, go to READ.
  - else `write_i` → latch the address the same way and latch `line_i` into the line buffer, set k=0, go to WRITE.
  - `read_i` and `write_i` both high is illegal. Read wins; the write is not serviced.
- READ:
  - `read_o`=1, `address_o` = latched address.
  - Each cycle with `resp_i`=1: `line_o[64k +: 64] <= burst_i`, k++.
  - Cycles with `resp_i`=0 are wait cycles: no change.
  - The beat that brings k from 3 to wrap (4th beat) → go to DONE.
- WRITE:
  - `write_o`=1, `burst_o = buffer[64k +: 64]`.
  - Each `resp_i`=1 means the memory consumed the beat: k++.
  - The 4th beat → go to DONE.
- DONE:
  - `resp_o`=1 for exactly one cycle; `read_o`/`write_o`=0.
  - Requests are ignored in this cycle; go to IDLE.
  - The cache drops its request on seeing `resp_o`. A request still high in the following IDLE cycle starts a new transaction.
- `line_o` holds the last completed read line until the next read overwrites it. During a read it updates beat by beat; it is valid only at `resp_o`.
- `burst_o` = 0 outside WRITE.
- `address_o` holds its last value outside READ/WRITE.
- `proto_err_o` is set by `resp_i`=1 in IDLE or DONE. It clears only on `rst`. Stray beats are otherwise ignored and do not advance k.
- Counter arithmetic: k wraps 3→0 on the final beat; no 3-bit count is kept.

## Timing
- Reset: state IDLE, k=0. `read_o`, `write_o`, `resp_o`, `proto_err_o` = 0. `address_o`, `burst_o`, `line_o` = 0.
- Reset mid-transaction aborts it: `read_o`/`write_o` low from the cycle after the `rst` edge, no `resp_o`, line buffer contents discarded.
- Request seen in IDLE at edge T → `read_o`/`write_o` high in cycle T+1. These outputs are registered from the state.
- Earliest beats fall in cycles T+1..T+4. `resp_o` is high in the cycle after the 4th beat (minimum T+5). Each wait cycle adds one cycle.
- `read_o`/`write_o` stay high through the cycle carrying the 4th beat and are low in the DONE cycle.
- `burst_o` updates to the next beat in the cycle after each `resp_i`.
- Back-to-back: next request accepted in the IDLE cycle following DONE. Minimum line-to-line period is 6 cycles.

## Test plan
- **Read, contiguous beats:** read_i, address 0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → `address_o`=0x0000_1220, `line_o`={44..,33..,22..,11..}, `resp_o` one cycle at T+5.
- **Write with waits:** write_i, `line_i`={D,C,B,A}; `resp_i` pattern 1,0,0,1,1,0,1 → `burst_o` presents A,B,B,B,C,D,D; `write_o` high for 7 cycles, then a single `resp_o`.
- **Simultaneous read_i and write_i:** a read transaction only; `write_o` never asserts.
- **Reset during READ after 2 beats:** `read_o`=0 the next cycle, no `resp_o`. A following read returns a full fresh line.
- **Stray `resp_i` in IDLE:** `proto_err_o` goes 1 and stays 1. A subsequent read still completes correctly with k starting at 0.
- **Request held through DONE:** read_i held 2 cycles past `resp_o` → second read starts, `read_o` re-asserts exactly one cycle after DONE.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
module cacheline_adaptor #(
    parameter int BURSTS  = 4,
    parameter int BURST_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    input  logic [BURSTS*BURST_W-1:0]   line_i,
    output logic [BURSTS*BURST_W-1:0]   line_o,
    output logic                        resp_o,
    output logic [31:0]                 address_o,
    output logic                        read_o,
    output logic                        write_o,
    output logic [BURST_W-1:0]          burst_o,
    input  logic [BURST_W-1:0]          burst_i,
    input  logic                        resp_i,
    output logic                        proto_err_o
);
    localparam int LW = BURSTS * BURST_W;
    localparam int KW = $clog2(BURSTS);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [LW-1:0]   r_buf;
    logic [LW-1:0]   r_line;
    logic [31:0]     r_addr;
    logic            r_read;
    logic            r_write;
    logic            r_resp;
    logic            r_err;
    logic            w_last;
    assign w_last      = r_k == KW'(BURSTS - 1);
    assign line_o      = r_line;
    assign address_o   = r_addr;
    assign read_o      = r_read;
    assign write_o     = r_write;
    assign resp_o      = r_resp;
    assign proto_err_o = r_err;
    assign burst_o     = r_state == WRITE ? r_buf[r_k*BURST_W +: BURST_W] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_buf   <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (resp_i && (r_state == IDLE || r_state == DONE))
                r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    if (read_i) begin
                        r_addr  <= {address_i[31:5], 5'b0};
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end else if (write_i) begin
                        r_addr  <= {address_i[31:5], 5'b0};
                        r_buf   <= line_i;
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                READ: if (resp_i) begin
                    r_line[r_k*BURST_W +: BURST_W] <= burst_i;
                    r_k <= r_k + KW'(1);
                    if (w_last) begin
                        r_read  <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                WRITE: if (resp_i) begin
                    r_k <= r_k + KW'(1);
                    if (w_last) begin
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed bench with a transaction-level model checked every cycle.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst, read_i, write_i, resp_i;
    logic [31:0]  address_i, address_o;
    logic [255:0] line_i, line_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_o, proto_err_o;
    int           total = 0;
    int           bad = 0;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i),
        .resp_i(resp_i), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // transaction-level model: mode 0 idle, 1 read, 2 write, 3 done
    int           m_mode = 0;
    int           m_beats = 0;
    logic [63:0]  m_wr [4];
    logic [255:0] m_line;
    logic [31:0]  m_addr;
    logic         m_err;
    bit           m_valid = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_mode = 0; m_beats = 0; m_line = '0; m_addr = '0; m_err = 0;
        end else begin
            if (resp_i && (m_mode == 0 || m_mode == 3)) m_err = 1;
            if (m_mode == 3) m_mode = 0;
            else if (m_mode == 0) begin
                if (read_i || write_i) begin
                    m_addr  = address_i - (address_i % 32);
                    m_beats = 0;
                    m_mode  = read_i ? 1 : 2;
                    for (int i = 0; i < 4; i++) m_wr[i] = line_i[64*i +: 64];
                end
            end else if (resp_i) begin
                if (m_mode == 1) m_line[64*m_beats +: 64] = burst_i;
                m_beats++;
                if (m_beats == 4) m_mode = 3;
            end
        end
    end

    always @(negedge clk) if (m_valid) begin
        chk("cyc_read_o", read_o, m_mode == 1);
        chk("cyc_write_o", write_o, m_mode == 2);
        chk("cyc_resp_o", resp_o, m_mode == 3);
        chk("cyc_burst_o", burst_o, m_mode == 2 ? m_wr[m_beats] : 64'd0);
        chk("cyc_address_o", address_o, m_addr);
        chk("cyc_line_o", line_o, m_line);
        chk("cyc_proto_err_o", proto_err_o, m_err);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic rd_beats(input logic [63:0] a, b, c, d);
        logic [63:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            resp_i = 1; burst_i = v[i];
            tick();
        end
        resp_i = 0; burst_i = '0;
    endtask

    initial begin
        logic [63:0] seen [7];
        logic [63:0] want [7];
        bit   pat [7];
        int   wcnt;
        rst = 1; read_i = 0; write_i = 0; resp_i = 0;
        address_i = '0; line_i = '0; burst_i = '0;
        tick(); tick();
        chk("rst_read_o", read_o, 0);
        chk("rst_resp_o", resp_o, 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        rst = 0;
        tick();

        read_i = 1; address_i = 32'h0000_1234;
        tick();
        chk("t1_read_o", read_o, 1);
        chk("t1_address_o", address_o, 32'h0000_1220);
        rd_beats({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        chk("t1_resp_o", resp_o, 1);
        chk("t1_read_o_done", read_o, 0);
        chk("t1_line_o", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        read_i = 0;
        tick();
        chk("t1_resp_pulse", resp_o, 0);

        write_i = 1; address_i = 32'h0000_8047;
        line_i = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        pat  = '{1, 0, 0, 1, 1, 0, 1};
        want = '{{16{4'hA}}, {16{4'hB}}, {16{4'hB}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}, {16{4'hD}}};
        wcnt = 0;
        tick();
        for (int i = 0; i < 7; i++) begin
            seen[i] = burst_o;
            if (write_o) wcnt++;
            resp_i = pat[i];
            tick();
        end
        resp_i = 0;
        for (int i = 0; i < 7; i++) chk($sformatf("t2_burst_%0d", i), seen[i], want[i]);
        chk("t2_write_cycles", wcnt, 7);
        chk("t2_resp_o", resp_o, 1);
        chk("t2_write_o_done", write_o, 0);
        chk("t2_burst_idle", burst_o, 0);
        write_i = 0;
        tick();

        read_i = 1; write_i = 1; address_i = 32'h0000_0040; wcnt = 0;
        tick();
        chk("t3_read_o", read_o, 1);
        for (int i = 0; i < 4; i++) begin
            if (write_o) wcnt++;
            resp_i = 1; burst_i = 64'(i + 100);
            tick();
        end
        resp_i = 0;
        chk("t3_resp_o", resp_o, 1);
        read_i = 0; write_i = 0;
        tick();
        if (write_o) wcnt++;
        chk("t3_no_write", wcnt, 0);

        read_i = 1; address_i = 32'h0000_0100;
        tick();
        resp_i = 1; burst_i = 64'hDEAD; tick();
        burst_i = 64'hBEEF; tick();
        rst = 1; resp_i = 0; read_i = 0;
        tick();
        chk("t4_read_o", read_o, 0);
        chk("t4_resp_o", resp_o, 0);
        rst = 0;
        tick();
        read_i = 1; address_i = 32'h0000_0120;
        tick();
        rd_beats({16{4'h5}}, {16{4'h6}}, {16{4'h7}}, {16{4'h8}});
        chk("t4_resp_o_fresh", resp_o, 1);
        chk("t4_line_o", line_o, {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}});
        read_i = 0;
        tick();

        resp_i = 1; burst_i = 64'h1234;
        tick();
        resp_i = 0;
        chk("t5_err_set", proto_err_o, 1);
        tick(); tick();
        chk("t5_err_sticky", proto_err_o, 1);
        read_i = 1; address_i = 32'h0000_0200;
        tick();
        rd_beats({16{4'h9}}, {16{4'hA}}, {16{4'hB}}, {16{4'hC}});
        chk("t5_line_o", line_o, {{16{4'hC}}, {16{4'hB}}, {16{4'hA}}, {16{4'h9}}});
        chk("t5_err_kept", proto_err_o, 1);

        tick();
        chk("t6_read_o_idle", read_o, 0);
        chk("t6_resp_gone", resp_o, 0);
        tick();
        chk("t6_read_o_again", read_o, 1);
        read_i = 0;
        rd_beats(64'h1, 64'h2, 64'h3, 64'h4);
        chk("t6_resp_o", resp_o, 1);
        chk("t6_line_o", line_o, {64'h4, 64'h3, 64'h2, 64'h1});
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
